// File: rtl/tcam_pkg.sv
// Shared definitions for the TCAM snoop filter: opcodes, result flag bit
// positions and the per-entry coherence state record.
package tcam_pkg;

    localparam logic [6:0] OP_READ_UNIQUE = 7'h01;
    localparam logic [6:0] OP_READ_SHARED = 7'h07;
    localparam logic [6:0] OP_EVICT       = 7'h1B;

    localparam int unsigned NID_W = 7;

    localparam int unsigned FLAG_HIT    = 0;
    localparam int unsigned FLAG_SNOOP  = 1;
    localparam int unsigned FLAG_ALLOC  = 2;
    localparam int unsigned FLAG_VICTIM = 3;

    // Tag storage is kept outside the record so the package stays width-agnostic.
    typedef struct packed {
        logic             valid;
        logic [NID_W-1:0] sharers;
        logic             is_unique;
    } entry_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_SHARED,
        REQ_UNIQUE,
        REQ_EVICT
    } req_e;

    function automatic req_e decode_req(input logic [6:0] opcode, input logic [NID_W-1:0] nid);
        req_e req;
        req = REQ_NONE;
        if (nid != '0) begin
            case (opcode)
                OP_READ_SHARED: req = REQ_SHARED;
                OP_READ_UNIQUE: req = REQ_UNIQUE;
                OP_EVICT:       req = REQ_EVICT;
                default:        req = REQ_NONE;
            endcase
        end
        return req;
    endfunction

endpackage

// File: rtl/tcam_match_array.sv
// Parallel masked tag compare across all entries, with lowest-index
// priority encoders for the first match and the first free slot.
module tcam_match_array
    import tcam_pkg::*;
#(
    parameter int unsigned WIDTH     = 33,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned MASK_BITS = 0,
    parameter int unsigned IDX_W     = $clog2(DEPTH)
) (
    input  logic [WIDTH-1:0] tag,
    input  logic [DEPTH-1:0] valid,
    input  logic [WIDTH-1:0] entry_tags [DEPTH],
    output logic [DEPTH-1:0] match,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx,
    output logic             free,
    output logic [IDX_W-1:0] free_idx
);

    localparam logic [WIDTH-1:0] CARE = {WIDTH{1'b1}} << MASK_BITS;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (((entry_tags[i] ^ tag) & CARE) == '0);
        end
    end

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (match[i] && !hit) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid[i] && !free) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tcam_snoop_filter.sv
// Fully-associative snoop filter: one request per cycle, sharer/ownership
// update at the clock edge, registered 4-bit result flag.
module tcam_snoop_filter
    import tcam_pkg::*;
#(
    parameter int unsigned WIDTH     = 33,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned MASK_BITS = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tag,
    input  logic [6:0]       opcode,
    input  logic [6:0]       NID,
    output logic [3:0]       flag
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    entry_t           entries    [DEPTH];
    logic [WIDTH-1:0] entry_tags [DEPTH];
    logic [IDX_W-1:0] ptr;

    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] match;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             free;
    logic [IDX_W-1:0] free_idx;

    req_e             req;
    entry_t           cur;
    entry_t           wr_entry;
    logic             wr_en;
    logic             wr_tag_en;
    logic [IDX_W-1:0] wr_idx;
    logic             alloc;
    logic             ptr_adv;
    logic [3:0]       flag_n;
    logic [6:0]       remaining;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_vec[i] = entries[i].valid;
        end
    end

    tcam_match_array #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .MASK_BITS (MASK_BITS),
        .IDX_W     (IDX_W)
    ) u_match (
        .tag        (tag),
        .valid      (valid_vec),
        .entry_tags (entry_tags),
        .match      (match),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .free       (free),
        .free_idx   (free_idx)
    );

    always_comb begin
        req       = decode_req(opcode, NID);
        cur       = entries[hit_idx];
        wr_entry  = cur;
        wr_en     = 1'b0;
        wr_tag_en = 1'b0;
        wr_idx    = hit_idx;
        alloc     = 1'b0;
        ptr_adv   = 1'b0;
        flag_n    = '0;
        remaining = cur.sharers & ~NID;

        case (req)
            REQ_SHARED: begin
                if (hit) begin
                    flag_n[FLAG_HIT]   = 1'b1;
                    flag_n[FLAG_SNOOP] = cur.is_unique && (cur.sharers != NID);
                    wr_entry.sharers   = cur.sharers | NID;
                    wr_entry.is_unique = 1'b0;
                    wr_en              = 1'b1;
                end else begin
                    alloc    = 1'b1;
                    wr_entry = '{valid: 1'b1, sharers: NID, is_unique: 1'b0};
                end
            end
            REQ_UNIQUE: begin
                if (hit) begin
                    flag_n[FLAG_HIT]   = 1'b1;
                    flag_n[FLAG_SNOOP] = (remaining != '0);
                    wr_entry.sharers   = NID;
                    wr_entry.is_unique = 1'b1;
                    wr_en              = 1'b1;
                end else begin
                    alloc    = 1'b1;
                    wr_entry = '{valid: 1'b1, sharers: NID, is_unique: 1'b1};
                end
            end
            REQ_EVICT: begin
                if (hit) begin
                    flag_n[FLAG_HIT] = 1'b1;
                    wr_entry.sharers = remaining;
                    if (remaining == '0) begin
                        wr_entry.valid     = 1'b0;
                        wr_entry.is_unique = 1'b0;
                    end
                    wr_en = 1'b1;
                end
            end
            default: ;
        endcase

        // A miss fills the first free slot; with none free, the round-robin victim.
        if (alloc) begin
            wr_en              = 1'b1;
            wr_tag_en          = 1'b1;
            flag_n[FLAG_ALLOC] = 1'b1;
            if (free) begin
                wr_idx = free_idx;
            end else begin
                wr_idx              = ptr;
                flag_n[FLAG_VICTIM] = 1'b1;
                ptr_adv             = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            ptr  <= '0;
            flag <= '0;
        end else begin
            if (wr_en) begin
                entries[wr_idx] <= wr_entry;
            end
            if (ptr_adv) begin
                ptr <= ptr + IDX_W'(1);
            end
            flag <= flag_n;
        end
    end

    // Tags are only meaningful behind a valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_tag_en) begin
            entry_tags[wr_idx] <= tag;
        end
    end

endmodule

// File: tb/tb_tcam_snoop_filter.sv
// Drives two filters (unmasked and 8-bit masked) with the same requests and
// compares their flags against a behavioural model of the sharer rules.
module tb_tcam_snoop_filter;

    localparam int unsigned WIDTH = 33;
    localparam int unsigned DEPTH = 16;
    localparam logic [6:0] RS = 7'h07;
    localparam logic [6:0] RU = 7'h01;
    localparam logic [6:0] EV = 7'h1B;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] tag = '0;
    logic [6:0]       opcode = '0;
    logic [6:0]       nid = '0;
    logic [3:0]       flag0;
    logic [3:0]       flag8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tcam_snoop_filter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MASK_BITS(0)) u_dut0 (
        .clk(clk), .reset(reset), .tag(tag), .opcode(opcode), .NID(nid), .flag(flag0)
    );

    tcam_snoop_filter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MASK_BITS(8)) u_dut8 (
        .clk(clk), .reset(reset), .tag(tag), .opcode(opcode), .NID(nid), .flag(flag8)
    );

    // Reference state, one directory per mask setting (0 -> unmasked, 1 -> 8 bits).
    bit               m_valid [2][DEPTH];
    logic [WIDTH-1:0] m_tag   [2][DEPTH];
    bit [6:0]         m_sh    [2][DEPTH];
    bit               m_uq    [2][DEPTH];
    int               m_ptr   [2];

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: flag=%b expected=%b (tag=%h op=%h nid=%b)", name, got, exp, tag, opcode, nid);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_valid[d][i] = 0;
                m_sh[d][i]    = '0;
                m_uq[d][i]    = 0;
            end
        end
    endtask

    task automatic model_step(input int d, input int mb, input logic [WIDTH-1:0] t,
                              input logic [6:0] op, input logic [6:0] n, output logic [3:0] f);
        int h;
        int slot;
        f = 4'b0000;
        if (n == 0 || !(op == RS || op == RU || op == EV)) return;
        h = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (h < 0 && m_valid[d][i] && ((m_tag[d][i] >> mb) == (t >> mb))) h = i;
        end
        if (h >= 0) begin
            f[0] = 1'b1;
            if (op == RS) begin
                if (m_uq[d][h] && m_sh[d][h] != n) f[1] = 1'b1;
                m_sh[d][h] = m_sh[d][h] | n;
                m_uq[d][h] = 0;
            end else if (op == RU) begin
                if ((m_sh[d][h] & ~n) != 0) f[1] = 1'b1;
                m_sh[d][h] = n;
                m_uq[d][h] = 1;
            end else begin
                m_sh[d][h] = m_sh[d][h] & ~n;
                if (m_sh[d][h] == 0) begin
                    m_valid[d][h] = 0;
                    m_uq[d][h]    = 0;
                end
            end
        end else if (op != EV) begin
            f[2] = 1'b1;
            slot = -1;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (!m_valid[d][i]) slot = i;
            end
            if (slot < 0) begin
                slot     = m_ptr[d];
                f[3]     = 1'b1;
                m_ptr[d] = (m_ptr[d] + 1) % DEPTH;
            end
            m_valid[d][slot] = 1;
            m_tag[d][slot]   = t;
            m_sh[d][slot]    = n;
            m_uq[d][slot]    = (op == RU);
        end
    endtask

    task automatic step(input logic [WIDTH-1:0] t, input logic [6:0] op, input logic [6:0] n);
        logic [3:0] e0;
        logic [3:0] e8;
        tag    = t;
        opcode = op;
        nid    = n;
        model_step(0, 0, t, op, n, e0);
        model_step(1, 8, t, op, n, e8);
        @(posedge clk);
        #1;
        check("model_m0", flag0, e0);
        check("model_m8", flag8, e8);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_m0", flag0, 4'b0000);
        check("reset_m8", flag8, 4'b0000);
        reset = 1'b0;
    endtask

    logic [WIDTH-1:0] pool [24];

    initial begin
        logic [WIDTH-1:0] t;
        logic [6:0]       op;
        logic [6:0]       n;
        logic [24:0]      hi;
        int               r;

        #1;
        do_reset();

        step(33'h0ABCDEFF, RS, 7'b0000001); check("rs_alloc", flag0, 4'b0100);
        step(33'h0ABCDEFF, RS, 7'b0000001); check("rs_held", flag0, 4'b0001);
        step(33'h0ABCDEFF, RU, 7'b0000010); check("ru_snoop", flag0, 4'b0011);
        step(33'h0ABCDEFF, RU, 7'b0000010); check("ru_held", flag0, 4'b0001);
        step(33'h0ABCDEFF, RS, 7'b0000100); check("rs_snoop", flag0, 4'b0011);
        step(33'h0ABCDEFF, RS, 7'b0000100); check("rs_held2", flag0, 4'b0001);

        step(33'h11223341, RS, 7'b0000001); check("t41_m0", flag0, 4'b0100);
        step(33'h11223314, RS, 7'b0000001); check("t14_m0", flag0, 4'b0100);
        check("t14_m8", flag8, 4'b0001);
        step(33'h11223144, RS, 7'b0000001); check("t144_m0", flag0, 4'b0100);

        step(33'h1, RS, 7'b0000100); check("ev_alloc", flag0, 4'b0100);
        step(33'h1, EV, 7'b0000100); check("ev_hit", flag0, 4'b0001);
        step(33'h1, EV, 7'b0000100); check("ev_miss", flag0, 4'b0000);

        step(33'h0ABCDEFF, 7'h55, 7'b0000001); check("bad_op", flag0, 4'b0000);
        step(33'h0ABCDEFF, RU, 7'b0000000);    check("null_nid", flag0, 4'b0000);

        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(WIDTH'(i + 1) << 12, RS, 7'b0000001);
            check("fill", flag0, 4'b0100);
        end
        step(33'h1_0000_0000, RS, 7'b0000001); check("victim0", flag0, 4'b1100);
        step(33'h1_0001_0000, RS, 7'b0000001); check("victim1", flag0, 4'b1100);
        step(33'h0_0000_1000, RS, 7'b0000001); check("old_tag", flag0, 4'b1100);

        do_reset();
        hi = 25'($urandom);
        for (int k = 0; k < 24; k++) begin
            if (k < 12) pool[k] = {hi, 8'($urandom)};
            else        pool[k] = {1'($urandom_range(0, 1)), 32'($urandom)};
        end
        t  = pool[0];
        op = RS;
        n  = 7'b0000001;
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 199) == 0) begin
                tag    = pool[$urandom_range(0, 23)];
                opcode = RS;
                nid    = 7'($urandom);
                do_reset();
                continue;
            end
            r = int'($urandom_range(0, 9));
            if (r != 9) begin
                t = pool[$urandom_range(0, 23)];
                if (r <= 2)      op = RS;
                else if (r <= 5) op = RU;
                else if (r <= 7) op = EV;
                else             op = 7'($urandom);
                n = ($urandom_range(0, 9) == 0) ? 7'b0 : 7'($urandom);
            end
            step(t, op, n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
